// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int REG_SIZE = 32;
    localparam int WIDTH    = 128;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_IC_RD = 3'd1,
        ARB_DC_RD = 3'd2,
        ARB_DC_WR = 3'd3,
        ARB_DONE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// Winner select among I-fetch, D-read and D-write-back requests.
// Latency: combinational.
// Backpressure: none; a grant of ARB_IDLE means no request is pending.
module mem_arbiter_prio_sel
    import mem_arbiter_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_rd_req,
    input  logic       dc_wr_req,
    input  logic       streak_full,
    output arb_state_t grant
);

    // A saturated D streak hands the port to a waiting I-fetch; otherwise
    // write-back beats refill so a dirty victim leaves before its line returns.
    always_comb begin
        grant = ARB_IDLE;
        if (ic_req && streak_full)
            grant = ARB_IC_RD;
        else if (dc_wr_req)
            grant = ARB_DC_WR;
        else if (dc_rd_req)
            grant = ARB_DC_RD;
        else if (ic_req)
            grant = ARB_IC_RD;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: I-cache refill, D-cache refill and write-back.
// Latency: mem_enable one cycle after req; ack one cycle after mem_ack.
// Backpressure: one transaction at a time; other requesters wait on their level req.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = REG_SIZE,
    parameter int LINE_W       = WIDTH,
    parameter int MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    arb_state_t state, state_nxt, grant;
    logic [3:0] d_streak;
    logic [3:0] d_streak_upd;
    logic       streak_full;
    logic       in_xfer;

    assign streak_full = (d_streak == STREAK_MAX);
    assign in_xfer     = (state == ARB_IC_RD) || (state == ARB_DC_RD) || (state == ARB_DC_WR);

    // Streak only grows while an I-fetch is actually being held off.
    assign d_streak_upd = !ic_read_req ? 4'd0 :
                          streak_full  ? d_streak : d_streak + 4'd1;

    mem_arbiter_prio_sel u_prio_sel (
        .ic_req      (ic_read_req),
        .dc_rd_req   (dc_read_req),
        .dc_wr_req   (dc_write_req),
        .streak_full (streak_full),
        .grant       (grant)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:                         state_nxt = grant;
            ARB_IC_RD, ARB_DC_RD, ARB_DC_WR:  if (mem_ack) state_nxt = ARB_DONE;
            ARB_DONE:                         state_nxt = ARB_IDLE;
            default:                          state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_streak     <= 4'd0;
            mem_enable   <= 1'b0;
            mem_rw       <= MEM_RD;
            mem_addr     <= '0;
            mem_data_out <= '0;
            ic_read_data <= '0;
            dc_read_data <= '0;
            ic_read_ack  <= 1'b0;
            dc_read_ack  <= 1'b0;
            dc_write_ack <= 1'b0;
        end else begin
            ic_read_ack  <= 1'b0;
            dc_read_ack  <= 1'b0;
            dc_write_ack <= 1'b0;

            if (state == ARB_IDLE && grant != ARB_IDLE) begin
                mem_enable <= 1'b1;
                mem_rw     <= (grant == ARB_DC_WR) ? MEM_WR : MEM_RD;
                case (grant)
                    ARB_IC_RD: mem_addr <= ic_read_addr;
                    ARB_DC_RD: mem_addr <= dc_read_addr;
                    ARB_DC_WR: begin
                        mem_addr     <= dc_write_addr;
                        mem_data_out <= dc_write_data;
                    end
                    default: ;
                endcase
            end

            if (in_xfer && mem_ack) begin
                mem_enable <= 1'b0;
                mem_rw     <= MEM_RD;
                case (state)
                    ARB_IC_RD: begin
                        ic_read_data <= mem_data_in;
                        ic_read_ack  <= 1'b1;
                        d_streak     <= 4'd0;
                    end
                    ARB_DC_RD: begin
                        dc_read_data <= mem_data_in;
                        dc_read_ack  <= 1'b1;
                        d_streak     <= d_streak_upd;
                    end
                    ARB_DC_WR: begin
                        dc_write_ack <= 1'b1;
                        d_streak     <= d_streak_upd;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_read_req, dc_read_req, dc_write_req;
    logic [AW-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
    logic [LW-1:0] dc_write_data, mem_data_in;
    logic          ic_read_ack, dc_read_ack, dc_write_ack;
    logic [LW-1:0] ic_read_data, dc_read_data, mem_data_out;
    logic          mem_enable, mem_rw, mem_ack;
    logic [AW-1:0] mem_addr;

    int n_cmp   = 0;
    int n_err   = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MAX_D_STREAK(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ic_read_req  (ic_read_req),
        .ic_read_addr (ic_read_addr),
        .ic_read_ack  (ic_read_ack),
        .ic_read_data (ic_read_data),
        .dc_read_req  (dc_read_req),
        .dc_read_addr (dc_read_addr),
        .dc_read_ack  (dc_read_ack),
        .dc_read_data (dc_read_data),
        .dc_write_req (dc_write_req),
        .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data),
        .dc_write_ack (dc_write_ack),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Total ack pulses seen, sampled clear of the clock edge.
    always @(posedge clk) begin
        #2;
        ack_cnt = ack_cnt + int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack);
    end

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input string tag);
        int k = 0;
        while (mem_enable !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, LW'(mem_enable), LW'(1));
    endtask

    task automatic mem_reply(input logic [LW-1:0] d);
        mem_data_in = d;
        mem_ack     = 1'b1;
        @(negedge clk);
        mem_ack     = 1'b0;
        mem_data_in = '0;
    endtask

    logic [LW-1:0] line1, line2, line3, pat_a5, pat_5a;
    logic [AW-1:0] exp_addr [6];
    int            a0;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        line1  = 128'hDEADBEEF_0000_0001_0000_0002_0000_0003;
        line2  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        line3  = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0;
        pat_a5 = {16{8'hA5}};
        pat_5a = {16{8'h5A}};
        exp_addr = '{32'h300, 32'h300, 32'h200, 32'h300, 32'h300, 32'h200};

        reset = 1'b1;
        ic_read_req = 0; dc_read_req = 0; dc_write_req = 0;
        ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0;
        dc_write_data = '0; mem_data_in = '0; mem_ack = 0;
        cyc(3);
        reset = 1'b0;
        chk("rst_en",    LW'(mem_enable), '0);
        chk("rst_rw",    LW'(mem_rw), '0);
        chk("rst_addr",  LW'(mem_addr), '0);
        chk("rst_dout",  mem_data_out, '0);
        chk("rst_icdat", ic_read_data, '0);
        chk("rst_dcdat", dc_read_data, '0);
        chk("rst_acks",  LW'({ic_read_ack, dc_read_ack, dc_write_ack}), '0);

        // I-fetch alone
        ic_read_req = 1; ic_read_addr = 32'h0000_0040;
        cyc(1);
        chk("t1_en",   LW'(mem_enable), LW'(1));
        chk("t1_rw",   LW'(mem_rw), '0);
        chk("t1_addr", LW'(mem_addr), LW'(32'h40));
        cyc(2);
        mem_reply(line1);
        chk("t1_ack",    LW'(ic_read_ack), LW'(1));
        chk("t1_data",   ic_read_data, line1);
        chk("t1_en_off", LW'(mem_enable), '0);
        ic_read_req = 0;
        cyc(1);
        chk("t1_ack_pulse", LW'(ic_read_ack), '0);
        cyc(1);

        // Write-back and refill together; write wins, inputs change mid-flight
        a0 = ack_cnt;
        dc_write_req = 1; dc_write_addr = 32'h100; dc_write_data = pat_a5;
        dc_read_req  = 1; dc_read_addr  = 32'h100;
        cyc(1);
        chk("t2_wr_en",   LW'(mem_enable), LW'(1));
        chk("t2_wr_rw",   LW'(mem_rw), LW'(1));
        chk("t2_wr_addr", LW'(mem_addr), LW'(32'h100));
        chk("t2_wr_dout", mem_data_out, pat_a5);
        dc_write_addr = 32'h999; dc_write_data = pat_5a;
        cyc(2);
        chk("t5_hold_addr", LW'(mem_addr), LW'(32'h100));
        chk("t5_hold_dout", mem_data_out, pat_a5);
        mem_reply('0);
        chk("t2_wr_ack",  LW'(dc_write_ack), LW'(1));
        chk("t2_rd_nack", LW'(dc_read_ack), '0);
        dc_write_req = 0;
        cyc(2);
        chk("t2_rd_en",   LW'(mem_enable), LW'(1));
        chk("t2_rd_rw",   LW'(mem_rw), '0);
        chk("t2_rd_addr", LW'(mem_addr), LW'(32'h100));
        cyc(1);
        mem_reply(line2);
        chk("t2_rd_ack",  LW'(dc_read_ack), LW'(1));
        chk("t2_rd_data", dc_read_data, line2);
        dc_read_req = 0;
        cyc(2);
        chk("t2_ack_total", LW'(ack_cnt - a0), LW'(2));

        // Anti-starvation: D side continuous, I-fetch held
        ic_read_req = 1; ic_read_addr = 32'h200;
        dc_read_req = 1; dc_read_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            wait_en($sformatf("t3_en%0d", i));
            chk($sformatf("t3_grant%0d", i), LW'(mem_addr), LW'(exp_addr[i]));
            cyc(1);
            mem_reply(LW'(i));
        end
        ic_read_req = 0; dc_read_req = 0;
        cyc(2);
        chk("t3_icdat", ic_read_data, LW'(5));
        chk("t3_dcdat", dc_read_data, LW'(4));

        // Reset in the middle of a D refill, stale mem_ack afterwards
        dc_read_req = 1; dc_read_addr = 32'h480;
        wait_en("t4_en");
        cyc(1);
        reset = 1;
        cyc(1);
        reset = 0;
        mem_ack = 1;
        a0 = ack_cnt;
        chk("t4_rst_en",    LW'(mem_enable), '0);
        chk("t4_rst_addr",  LW'(mem_addr), '0);
        chk("t4_rst_dcdat", dc_read_data, '0);
        chk("t4_rst_icdat", ic_read_data, '0);
        cyc(1);
        mem_ack = 0;
        chk("t4_no_ack", LW'(dc_read_ack), '0);
        chk("t4_regrant_en",   LW'(mem_enable), LW'(1));
        chk("t4_regrant_addr", LW'(mem_addr), LW'(32'h480));
        cyc(1);
        mem_reply(line3);
        chk("t4_ack",  LW'(dc_read_ack), LW'(1));
        chk("t4_data", dc_read_data, line3);
        dc_read_req = 0;
        cyc(2);
        chk("t4_ack_total", LW'(ack_cnt - a0), LW'(1));

        // Spurious mem_ack while idle
        a0 = ack_cnt;
        cyc(1);
        mem_ack = 1;
        cyc(1);
        mem_ack = 0;
        cyc(2);
        chk("t6_no_ack", LW'(ack_cnt - a0), '0);
        chk("t6_en",     LW'(mem_enable), '0);
        ic_read_req = 1; ic_read_addr = 32'h7C0;
        cyc(1);
        chk("t6_idle_grant", LW'(mem_enable), LW'(1));
        chk("t6_addr",       LW'(mem_addr), LW'(32'h7C0));
        cyc(1);
        mem_reply(line2);
        chk("t6_ack",  LW'(ic_read_ack), LW'(1));
        chk("t6_data", ic_read_data, line2);
        ic_read_req = 0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
